// File: rtl/packet_arbiter.sv
// Packet-atomic round-robin arbiter: merges NUM_INPUTS upstream packet FIFOs into one
// downstream FIFO, forwarding whole packets and cutting any packet at MAX_WORDS words.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no owner; search requesters round-robin starting after last
// ST_PASS | owner last_q forwards words until out_end (natural or forced)
module packet_arbiter #(
    parameter int WORD_SIZE  = 4,
    parameter int NUM_INPUTS = 4,
    parameter int MAX_WORDS  = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_INPUTS-1:0]           enable,
    input  logic [NUM_INPUTS-1:0]           in_nempty,
    input  logic [NUM_INPUTS*WORD_SIZE-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]           in_end,
    output logic [NUM_INPUTS-1:0]           in_pop,
    input  logic                            out_full,
    output logic                            out_shift,
    output logic [WORD_SIZE-1:0]            out_data,
    output logic                            out_end,
    output logic [NUM_INPUTS-1:0]           grant,
    output logic                            busy,
    output logic                            truncated
);
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int CNT_W = $clog2(MAX_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

    typedef enum logic {ST_IDLE, ST_PASS} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_INPUTS-1:0] grant_q, grant_d;
    logic                  truncated_q, truncated_d;

    logic [NUM_INPUTS-1:0] req;
    logic [IDX_W-1:0]      pick, cand, sel;
    logic                  pick_valid;
    logic                  src_nempty, src_end;
    logic                  xfer, force_end;

    assign req = enable & in_nempty;

    // First requester at or after last_q+1, wrapping; only the first hit is kept.
    always_comb begin
        pick       = '0;
        cand       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_INPUTS);
            if (!pick_valid && req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Source mux; in IDLE the data path simply follows input 0.
    always_comb begin
        sel        = (state_q == ST_PASS) ? last_q : '0;
        out_data   = '0;
        src_end    = 1'b0;
        src_nempty = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel == IDX_W'(i)) begin
                out_data   = in_data[i*WORD_SIZE +: WORD_SIZE];
                src_end    = in_end[i];
                src_nempty = in_nempty[i];
            end
        end
    end

    assign busy      = (state_q == ST_PASS);
    assign force_end = busy && (cnt_q == LAST_CNT);
    assign xfer      = busy && src_nempty && !out_full;
    assign out_shift = xfer;
    assign out_end   = src_end | force_end;
    assign in_pop    = grant_q & {NUM_INPUTS{xfer}};
    assign grant     = grant_q;
    assign truncated = truncated_q;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        truncated_d = truncated_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_PASS;
                    last_d  = pick;
                    grant_d = NUM_INPUTS'(1) << pick;
                    cnt_d   = '0;
                end
            end
            ST_PASS: begin
                if (xfer) begin
                    if (out_end) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        if (force_end && !src_end) truncated_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(NUM_INPUTS - 1);
            cnt_q       <= '0;
            grant_q     <= '0;
            truncated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            truncated_q <= truncated_d;
        end
    end

endmodule
